// File: rtl/serial_pkg.sv
`default_nettype none
// ============================================================================
// Package     : serial_pkg
// Description : Types and constants shared by the serial link transmitter
//               and receiver.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_pkg;

  // Word width used on both ends of the serial link
  localparam int SERIAL_WORD_W = 8;

  // Transmitter control states
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT    = 2'd1,
    WAIT_ACK = 2'd2
  } tx_state_t;

endpackage
`default_nettype wire

// File: rtl/serializador.sv
`default_nettype none
// ============================================================================
// Module      : serializador
// Description : Parallel-to-serial transmitter. Takes one word from the queue,
//               shifts it out MSB first with a per-bit write strobe, then
//               waits for the far-end acknowledge or a timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module serializador
  import serial_pkg::*;
#(
  parameter int DATA_WIDTH  = SERIAL_WORD_W,
  parameter int ACK_TIMEOUT = 32
) (
  input  logic                  clock_100KHz,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  valid_in,
  output logic                  ready_out,
  output logic                  data_out,
  output logic                  write_out,
  input  logic                  ack_in,
  output logic                  done_out,
  output logic                  err_out,
  output logic [7:0]            frames_out
);

  localparam int CNT_W = (DATA_WIDTH  > 1) ? $clog2(DATA_WIDTH)  : 1;
  localparam int TO_W  = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(ACK_TIMEOUT - 1);

  tx_state_t             state;
  logic [DATA_WIDTH-1:0] shreg;
  logic [CNT_W-1:0]      bit_cnt;
  logic [TO_W-1:0]       to_cnt;

  // Frame sequencer: the MSB is driven on the accept edge itself, so the
  // remaining DATA_WIDTH-1 bits come from the shift register and the bit
  // counter reaching zero marks the cycle in which the last bit is on the line.
  always_ff @(posedge clock_100KHz or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      to_cnt     <= '0;
      frames_out <= '0;
      ready_out  <= 1'b1;
      data_out   <= 1'b0;
      write_out  <= 1'b0;
      done_out   <= 1'b0;
      err_out    <= 1'b0;
    end else begin
      done_out <= 1'b0;
      err_out  <= 1'b0;
      case (state)
        IDLE: begin
          data_out  <= 1'b0;
          write_out <= 1'b0;
          if (valid_in && ready_out) begin
            data_out  <= data_in[DATA_WIDTH-1];
            write_out <= 1'b1;
            shreg     <= data_in << 1;
            bit_cnt   <= BIT_LAST;
            ready_out <= 1'b0;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          if (bit_cnt == '0) begin
            // last bit has just been on the line; stop strobing
            data_out  <= 1'b0;
            write_out <= 1'b0;
            to_cnt    <= '0;
            state     <= WAIT_ACK;
          end else begin
            data_out  <= shreg[DATA_WIDTH-1];
            write_out <= 1'b1;
            shreg     <= shreg << 1;
            bit_cnt   <= bit_cnt - 1'b1;
          end
        end
        WAIT_ACK: begin
          data_out  <= 1'b0;
          write_out <= 1'b0;
          // acknowledge takes priority over a coincident timeout
          if (ack_in) begin
            done_out   <= 1'b1;
            frames_out <= frames_out + 8'd1;
            ready_out  <= 1'b1;
            state      <= IDLE;
          end else if (to_cnt == TO_LAST) begin
            err_out   <= 1'b1;
            ready_out <= 1'b1;
            state     <= IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        default: begin
          ready_out <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serializador.sv
`default_nettype none
// ============================================================================
// Module      : tb_serializador
// Description : Self-checking bench for serializador with a frame-level
//               reference model (bit order, ack/timeout outcome, frame count).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serializador;

  localparam int DW = 8;
  localparam int AT = 32;

  logic          clock_100KHz = 1'b0;
  logic          reset;
  logic [DW-1:0] data_in;
  logic          valid_in;
  logic          ready_out;
  logic          data_out;
  logic          write_out;
  logic          ack_in;
  logic          done_out;
  logic          err_out;
  logic [7:0]    frames_out;

  int total = 0;
  int bad   = 0;
  int exp_frames = 0;

  // 100 kHz-style free-running clock (period is arbitrary in simulation)
  always #5 clock_100KHz = ~clock_100KHz;

  serializador #(.DATA_WIDTH(DW), .ACK_TIMEOUT(AT)) dut (
    .clock_100KHz (clock_100KHz),
    .reset        (reset),
    .data_in      (data_in),
    .valid_in     (valid_in),
    .ready_out    (ready_out),
    .data_out     (data_out),
    .write_out    (write_out),
    .ack_in       (ack_in),
    .done_out     (done_out),
    .err_out      (err_out),
    .frames_out   (frames_out)
  );

  // Send one word from an idle transmitter and observe the frame.
  // d = WAIT_ACK cycle index (0 = first) on which ack is raised, -1 = never.
  // end_idx = WAIT_ACK cycle index on which done/err is first seen.
  task automatic run_frame(input logic [DW-1:0] w, input int d, input bit ack_in_shift,
                           output logic [DW-1:0] bits, output int nwr, output int end_idx,
                           output bit got_done, output bit got_err, output bit rdy_end);
    bits = '0; nwr = 0; end_idx = -1; got_done = 0; got_err = 0; rdy_end = 0;
    data_in  = w;
    valid_in = 1'b1;
    @(negedge clock_100KHz);
    valid_in = 1'b0;
    data_in  = DW'($urandom);
    ack_in   = ack_in_shift;
    for (int i = 0; i < 2*DW && write_out === 1'b1; i++) begin
      bits = {bits[DW-2:0], data_out};
      nwr++;
      @(negedge clock_100KHz);
    end
    ack_in = 1'b0;
    for (int idx = 0; idx <= AT + 4; idx++) begin
      ack_in = (idx == d);
      @(negedge clock_100KHz);
      ack_in = 1'b0;
      if (done_out === 1'b1 || err_out === 1'b1) begin
        end_idx  = idx + 1;
        got_done = done_out;
        got_err  = err_out;
        rdy_end  = ready_out;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; valid_in = 1'b0; ack_in = 1'b0; data_in = '0;
    repeat (3) @(negedge clock_100KHz);
    total++;
    if ({ready_out, data_out, write_out, done_out, err_out, frames_out} !== {5'b10000, 8'd0}) begin
      bad++;
      $display("FAIL reset_hold got=%b exp=%b", {ready_out, data_out, write_out, done_out, err_out, frames_out}, {5'b10000, 8'd0});
    end
    reset = 1'b1;
    @(negedge clock_100KHz);
    total++;
    if ({ready_out, data_out, write_out, done_out, err_out, frames_out} !== {5'b10000, 8'd0}) begin
      bad++;
      $display("FAIL reset_release got=%b exp=%b", {ready_out, data_out, write_out, done_out, err_out, frames_out}, {5'b10000, 8'd0});
    end
    exp_frames = 0;
  endtask

  task automatic test_basic();
    logic [DW-1:0] bits; int nwr, idx; bit gd, ge, rdy;
    run_frame(8'hA5, 1, 1'b0, bits, nwr, idx, gd, ge, rdy);
    exp_frames = (exp_frames + 1) % 256;
    total++;
    if (bits !== 8'hA5 || nwr != DW) begin
      bad++; $display("FAIL basic_bits got=%h/%0d exp=a5/%0d", bits, nwr, DW);
    end
    total++;
    if ({gd, ge, rdy} !== 3'b101 || idx != 2) begin
      bad++; $display("FAIL basic_done got=done%0d err%0d rdy%0d idx%0d exp=done1 err0 rdy1 idx2", gd, ge, rdy, idx);
    end
    total++;
    if (frames_out !== 8'(exp_frames)) begin
      bad++; $display("FAIL basic_frames got=%0d exp=%0d", frames_out, exp_frames);
    end
    @(negedge clock_100KHz);
    total++;
    if (done_out !== 1'b0 || ready_out !== 1'b1) begin
      bad++; $display("FAIL basic_pulse got=done%b rdy%b exp=done0 rdy1", done_out, ready_out);
    end
  endtask

  task automatic test_timeout();
    logic [DW-1:0] bits, w; int nwr, idx; bit gd, ge, rdy;
    w = DW'($urandom);
    run_frame(w, -1, 1'b0, bits, nwr, idx, gd, ge, rdy);
    total++;
    if ({gd, ge, rdy} !== 3'b011 || idx != AT || bits !== w) begin
      bad++; $display("FAIL timeout got=done%0d err%0d rdy%0d idx%0d bits%h exp=done0 err1 rdy1 idx%0d bits%h", gd, ge, rdy, idx, bits, AT, w);
    end
    total++;
    if (frames_out !== 8'(exp_frames)) begin
      bad++; $display("FAIL timeout_frames got=%0d exp=%0d", frames_out, exp_frames);
    end
  endtask

  // Ack at the window edges, including the cycle where the timeout also expires
  task automatic test_ack_window();
    int ds[4] = '{0, AT-2, AT-1, AT};
    logic [DW-1:0] bits, w; int nwr, idx, exp_idx; bit gd, ge, rdy, exp_done;
    foreach (ds[k]) begin
      w = DW'($urandom);
      run_frame(w, ds[k], 1'b0, bits, nwr, idx, gd, ge, rdy);
      exp_done = (ds[k] >= 0 && ds[k] < AT);
      exp_idx  = exp_done ? ds[k] + 1 : AT;
      if (exp_done) exp_frames = (exp_frames + 1) % 256;
      total++;
      if (gd !== exp_done || ge !== !exp_done || idx != exp_idx || frames_out !== 8'(exp_frames)) begin
        bad++; $display("FAIL ack_window d=%0d got=done%0d err%0d idx%0d fr%0d exp=done%0d err%0d idx%0d fr%0d",
                        ds[k], gd, ge, idx, frames_out, exp_done, !exp_done, exp_idx, exp_frames);
      end
    end
  endtask

  task automatic test_ack_in_shift();
    logic [DW-1:0] bits, w; int nwr, idx; bit gd, ge, rdy;
    w = DW'($urandom);
    run_frame(w, -1, 1'b1, bits, nwr, idx, gd, ge, rdy);
    total++;
    if ({gd, ge} !== 2'b01 || idx != AT || frames_out !== 8'(exp_frames) || bits !== w) begin
      bad++; $display("FAIL ack_in_shift got=done%0d err%0d idx%0d fr%0d exp=done0 err1 idx%0d fr%0d", gd, ge, idx, frames_out, AT, exp_frames);
    end
  endtask

  task automatic test_back_to_back();
    int acc[$]; logic [2*DW-1:0] got; int nbits, ndone;
    got = '0; nbits = 0; ndone = 0;
    data_in = 8'h3C; valid_in = 1'b1; ack_in = 1'b1;
    for (int c = 0; c < 24; c++) begin
      if (valid_in && ready_out) acc.push_back(c);
      @(negedge clock_100KHz);
      if (acc.size() == 1) data_in = 8'hC3;
      if (acc.size() == 2) valid_in = 1'b0;
      if (write_out === 1'b1) begin got = {got[2*DW-2:0], data_out}; nbits++; end
      if (done_out === 1'b1) ndone++;
    end
    ack_in = 1'b0;
    exp_frames = (exp_frames + 2) % 256;
    total++;
    if (acc.size() != 2 || acc[0] != 0 || acc[1] != DW + 2) begin
      bad++; $display("FAIL b2b_period got=accepts%0d second_at%0d exp=accepts2 second_at%0d", acc.size(), (acc.size() > 1) ? acc[1] : -1, DW + 2);
    end
    total++;
    if (got !== 16'h3CC3 || nbits != 2*DW) begin
      bad++; $display("FAIL b2b_bits got=%h/%0d exp=3cc3/%0d", got, nbits, 2*DW);
    end
    total++;
    if (ndone != 2 || frames_out !== 8'(exp_frames) || ready_out !== 1'b1) begin
      bad++; $display("FAIL b2b_done got=done%0d fr%0d rdy%b exp=done2 fr%0d rdy1", ndone, frames_out, ready_out, exp_frames);
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] bits, w; int nwr, idx, d, exp_idx; bit gd, ge, rdy, exp_done;
    for (int k = 0; k < 20; k++) begin
      w = DW'($urandom);
      d = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, AT + 2));
      run_frame(w, d, 1'($urandom_range(0, 1)), bits, nwr, idx, gd, ge, rdy);
      exp_done = (d >= 0 && d < AT);
      exp_idx  = exp_done ? d + 1 : AT;
      if (exp_done) exp_frames = (exp_frames + 1) % 256;
      total++;
      if (bits !== w || nwr != DW || gd !== exp_done || ge !== !exp_done || idx != exp_idx ||
          rdy !== 1'b1 || frames_out !== 8'(exp_frames)) begin
        bad++; $display("FAIL random k=%0d w=%h d=%0d got=bits%h n%0d done%0d err%0d idx%0d rdy%0d fr%0d exp=bits%h n%0d done%0d err%0d idx%0d rdy1 fr%0d",
                        k, w, d, bits, nwr, gd, ge, idx, rdy, frames_out, w, DW, exp_done, !exp_done, exp_idx, exp_frames);
      end
    end
  endtask

  task automatic test_reset_mid();
    int stray;
    data_in = 8'hA5; valid_in = 1'b1;
    @(negedge clock_100KHz);
    valid_in = 1'b0;
    repeat (2) @(negedge clock_100KHz);
    total++;
    if (write_out !== 1'b1) begin
      bad++; $display("FAIL reset_mid_pre got=write%b exp=write1", write_out);
    end
    #2 reset = 1'b0;
    #1;
    total++;
    if ({ready_out, data_out, write_out, done_out, err_out, frames_out} !== {5'b10000, 8'd0}) begin
      bad++; $display("FAIL reset_mid_async got=%b exp=%b", {ready_out, data_out, write_out, done_out, err_out, frames_out}, {5'b10000, 8'd0});
    end
    @(negedge clock_100KHz);
    reset = 1'b1;
    exp_frames = 0;
    stray = 0;
    for (int c = 0; c < AT + DW + 4; c++) begin
      @(negedge clock_100KHz);
      if (err_out !== 1'b0 || done_out !== 1'b0 || write_out !== 1'b0 || ready_out !== 1'b1 || frames_out !== 8'd0) stray++;
    end
    total++;
    if (stray != 0) begin
      bad++; $display("FAIL reset_mid_after got=%0d bad cycles exp=0", stray);
    end
  endtask

  task automatic test_wrap();
    logic [DW-1:0] bits; int nwr, idx; bit gd, ge, rdy;
    for (int k = 0; k < 256; k++) begin
      run_frame(DW'($urandom), 0, 1'b0, bits, nwr, idx, gd, ge, rdy);
      exp_frames = (exp_frames + 1) % 256;
      if (k == 254) begin
        total++;
        if (frames_out !== 8'd255) begin
          bad++; $display("FAIL wrap_255 got=%0d exp=255", frames_out);
        end
      end
    end
    total++;
    if (frames_out !== 8'(exp_frames) || frames_out !== 8'd0) begin
      bad++; $display("FAIL wrap_0 got=%0d exp=0", frames_out);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_timeout();
    test_ack_window();
    test_ack_in_shift();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/serializador.md
# serializador

Parallel-to-serial transmitter for the link's outbound direction: takes one word at a time from the queue's parallel output and shifts it out one bit per clock with a per-bit write strobe. It waits for an acknowledge from the far-end deserializer before accepting the next word. Sits between the FILA output and the serial line, in the `clock_100KHz` domain.

## Interface
- `DATA_WIDTH`, default 8: word width; bits sent per frame.
- `ACK_TIMEOUT`, default 32: cycles to wait in WAIT_ACK before abandoning the frame.
- `clock_100KHz`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low; all state cleared while low.
- `data_in`  in  DATA_WIDTH  parallel word from queue.
- `valid_in`  in  1  word present on `data_in`.
- `ready_out`  out  1  transmitter idle; word accepted on the edge where `valid_in && ready_out`.
- `data_out`  out  1  serial bit, MSB first.
- `write_out`  out  1  `data_out` is a valid bit this cycle.
- `ack_in`  in  1  far end has consumed the frame.
- `done_out`  out  1  one-cycle pulse when the frame is acknowledged.
- `err_out`  out  1  one-cycle pulse when `ACK_TIMEOUT` expires.
- `frames_out`  out  8  count of acknowledged frames; wraps 255→0.

## Operation
- States: IDLE, SHIFT, WAIT_ACK.
- IDLE
  - `ready_out=1`.
  - On `valid_in`: load the shift register with `data_in`, set the bit counter to `DATA_WIDTH-1`, go to SHIFT.
- SHIFT
  - Each cycle: `data_out` = shift-register MSB, `write_out=1`, shift left by one, decrement the counter.
  - After the bit with counter 0: go to WAIT_ACK.
- WAIT_ACK
  - `write_out=0`, `data_out=0`; the timeout counter increments each cycle.
  - If `ack_in` is sampled high: pulse `done_out`, increment `frames_out`, go to IDLE.
  - Else if the timeout counter reaches `ACK_TIMEOUT-1`: pulse `err_out`, go to IDLE. The frame is dropped and `frames_out` is unchanged.
- `ack_in` is ignored in IDLE and SHIFT.
- An `ack_in` arriving on the same edge as the timeout wins: `done_out` pulses, not `err_out`.
- `valid_in` while not ready is ignored. The word is not latched, and the upstream must hold it.
- Counters are sized with `$clog2`. `frames_out` is 8-bit modular.

## Timing
- Reset values (asserted, async): state IDLE, `ready_out=1`, `data_out=0`, `write_out=0`, `done_out=0`, `err_out=0`, `frames_out=0`, shift register and counters 0.
- Reset is deasserted synchronously to the clock by the top level. Reset mid-frame aborts the frame immediately, with no `err_out`.
- All outputs are registered.
- Latency: accept at edge N. The first bit appears at N+1, and the last bit is valid during cycle N+DATA_WIDTH.
- `write_out` is high for exactly `DATA_WIDTH` consecutive cycles per frame.
- Best case, `ack_in` is high on the first WAIT_ACK cycle:
  - `done_out` at N+DATA_WIDTH+2;
  - `ready_out` high again in the same cycle.
  - Minimum frame period is `DATA_WIDTH+2` cycles.
- Timeout: `err_out` pulses `ACK_TIMEOUT` cycles after entering WAIT_ACK.

## Structure
- Shared package `serial_pkg`:
  - `tx_state_t` enum (IDLE, SHIFT, WAIT_ACK);
  - default width constant `SERIAL_WORD_W=8`.
  - The deserializer reuses the width constant.
- Single module, no sub-modules. It contains one state register, one shift register, the bit counter, the timeout counter and the frame counter.

## Test plan
- Reset low mid-SHIFT of 0xA5 → all outputs return to reset values immediately. After release, `ready_out=1` and `frames_out=0`.
- `DATA_WIDTH=8`, `data_in=0xA5`, `valid_in` for 1 cycle, `ack_in` high 2 cycles after the last bit → `data_out` = 1,0,1,0,0,1,0,1 under 8 `write_out` cycles; `done_out` pulse; `frames_out=1`.
- No `ack_in`, `ACK_TIMEOUT=32` → `err_out` pulses 32 cycles into WAIT_ACK, `ready_out` returns, `frames_out` unchanged.
- `valid_in` held high with 0x3C then 0xC3 and an immediate ack each time → both frames sent back-to-back with a 10-cycle period. The second word is not latched during SHIFT.
- `ack_in` pulsed during SHIFT, then never again → ignored; the frame ends in `err_out`.
- 256 acknowledged frames → `frames_out` wraps to 0.
